sisc_mem_resp: RTL and testbench

- Responder (memory side) for the SISC word-addressed fetch/load/store request interface; the processor core is the initiator.
- Accepts one request at a time and waits a fixed number of cycles, modelling slow memory.
- Returns a read word or a write acknowledge through a valid/ready response channel.
- Used as the memory model behind the core's fetch path, and as a data-memory responder for load/store bring-up.

---
 rtl/sisc_mem_resp.sv | 147 ++++++++++++++
 tb/tb_sisc_mem_resp.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_mem_resp.sv
// SISC word-addressed memory responder: one request at a time, fixed wait states, valid/ready
// response. Optional RESP stall counter enabled by defining SISC_MEM_STALL_CNT_EN.
module sisc_mem_resp #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
`ifdef SISC_MEM_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_accept;
  logic              w_access;
  logic              w_rsp_done;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;

  assign w_accept   = (r_state == StIdle) && req_valid;
  // The access edge ends a WAIT stretch of WAIT_CYC+1 cycles, so the response is visible
  // WAIT_CYC+1 edges after the accepting edge.
  assign w_access   = (r_state == StWait) && (r_cnt == 4'd0);
  assign w_rsp_done = (r_state == StResp) && rsp_ready;
  assign w_in_range = 32'(r_addr) < DEPTH;
  assign w_idx      = r_addr[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (req_valid) w_state_d = StWait;
      StWait:  if (r_cnt == 4'd0) w_state_d = StResp;
      StResp:  if (rsp_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    unique case (r_state)
      StIdle: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      StWait: begin
        rsp_valid = 1'b0;
      end
      StResp: begin
        rsp_valid = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_cnt   <= 4'(WAIT_CYC);
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end else if ((r_state == StWait) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_access) begin
      r_rdata <= (w_in_range && !r_we) ? r_mem[w_idx] : '0;
      r_err   <= !w_in_range;
    end else if (w_rsp_done) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end
  end

  // Storage has no reset; a reset before the access edge drops the pending write.
  always_ff @(posedge clk) begin
    if (w_access && r_we && w_in_range) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

`ifdef SISC_MEM_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_stall_cnt <= 16'd0;
    end else if ((r_state == StResp) && !rsp_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_sisc_mem_resp.sv
// Bench for sisc_mem_resp: a WAIT_CYC=2 instance (index 0) and a WAIT_CYC=0 instance (index 1),
// table-driven requests with a response scoreboard plus hand-written corner sequences.
module tb_sisc_mem_resp;

  logic        clk;
  logic        rst_f;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [15:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        busy      [2];
`ifdef SISC_MEM_STALL_CNT_EN
  logic [15:0] stall_cnt [2];
`endif

  int n_total = 0;
  int n_pass  = 0;
  logic [32:0] sb_q[$];

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  sisc_mem_resp #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .WAIT_CYC(2)) u_dut_w2 (
    .clk       (clk),
    .rst_f     (rst_f),
    .req_valid (req_valid[0]),
    .req_ready (req_ready[0]),
    .req_we    (req_we[0]),
    .req_addr  (req_addr[0]),
    .req_wdata (req_wdata[0]),
    .rsp_valid (rsp_valid[0]),
    .rsp_ready (rsp_ready[0]),
    .rsp_rdata (rsp_rdata[0]),
    .rsp_err   (rsp_err[0]),
    .busy      (busy[0])
`ifdef SISC_MEM_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt[0])
`endif
  );

  sisc_mem_resp #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .WAIT_CYC(0)) u_dut_w0 (
    .clk       (clk),
    .rst_f     (rst_f),
    .req_valid (req_valid[1]),
    .req_ready (req_ready[1]),
    .req_we    (req_we[1]),
    .req_addr  (req_addr[1]),
    .req_wdata (req_wdata[1]),
    .rsp_valid (rsp_valid[1]),
    .rsp_ready (rsp_ready[1]),
    .rsp_rdata (rsp_rdata[1]),
    .rsp_err   (rsp_err[1]),
    .busy      (busy[1])
`ifdef SISC_MEM_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Wait for rsp_valid at falling edges; lat counts edges after the accepting edge.
  task automatic wait_rsp(input int s, output int lat);
    lat = 0;
    @(negedge clk);
    while (!rsp_valid[s] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_req(input int s, input logic we, input logic [15:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input string name);
    int lat;
    int exp_lat;
    logic [32:0] exp;
    exp_lat = (s == 1) ? 1 : 3;
    @(negedge clk);
    check({name, " req_ready"}, 32'(req_ready[s]), 32'd1);
    req_valid[s] = 1'b1;
    req_we[s]    = we;
    req_addr[s]  = addr;
    req_wdata[s] = wdata;
    sb_q.push_back({exp_err, exp_rdata});
    @(posedge clk);
    #1;
    req_valid[s] = 1'b0;
    wait_rsp(s, lat);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 33'h1_FFFF_FFFF;
    check({name, " rdata"}, rsp_rdata[s], exp[31:0]);
    check({name, " err"}, 32'(rsp_err[s]), 32'(exp[32]));
    @(negedge clk);
    check({name, " idle valid"}, 32'(rsp_valid[s]), 32'd0);
    check({name, " idle rdata"}, rsp_rdata[s], 32'd0);
  endtask

  initial begin
    int lat;
    logic [32:0] exp;

    vecs[0]  = '{1'b1, 16'h0007, 32'h00000000, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 16'h0005, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b0, 16'h0005, 32'h00000000, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 16'h0000, 32'hCAFEF00D, 32'h00000000, 1'b0};
    vecs[4]  = '{1'b1, 16'h0100, 32'h12345678, 32'h00000000, 1'b1};
    vecs[5]  = '{1'b0, 16'h0100, 32'h00000000, 32'h00000000, 1'b1};
    vecs[6]  = '{1'b0, 16'h0000, 32'h00000000, 32'hCAFEF00D, 1'b0};
    vecs[7]  = '{1'b1, 16'h00FF, 32'h11111111, 32'h00000000, 1'b0};
    vecs[8]  = '{1'b1, 16'hFFFF, 32'h99999999, 32'h00000000, 1'b1};
    vecs[9]  = '{1'b0, 16'h00FF, 32'h00000000, 32'h11111111, 1'b0};
    vecs[10] = '{1'b0, 16'h0007, 32'h00000000, 32'h00000000, 1'b0};

    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0;
      req_we[s]    = 1'b0;
      req_addr[s]  = 16'h0;
      req_wdata[s] = 32'h0;
      rsp_ready[s] = 1'b1;
    end
    rst_f = 1'b0;
    #1;
    check("reset req_ready", 32'(req_ready[0]), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst_f = 1'b1;
    @(negedge clk);
    check("post-reset req_ready", 32'(req_ready[0]), 32'd1);
    check("post-reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("post-reset busy", 32'(busy[0]), 32'd0);
    check("post-reset rdata", rsp_rdata[0], 32'd0);
    check("post-reset err", 32'(rsp_err[0]), 32'd0);
    check("post-reset w0 req_ready", 32'(req_ready[1]), 32'd1);
`ifdef SISC_MEM_STALL_CNT_EN
    check("post-reset stall_cnt", 32'(stall_cnt[0]), 32'd0);
`endif

    for (int i = 0; i < 11; i++) begin
      do_req(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err,
             $sformatf("vec%0d", i));
    end

    // Backpressure: hold rsp_ready low for five RESP cycles, poke a write that must be ignored.
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0]  = 16'h0005;
    sb_q.push_back({1'b0, 32'hDEADBEEF});
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    wait_rsp(0, lat);
    check("bp latency", 32'(lat), 32'd3);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 33'h1_FFFF_FFFF;
    check("bp rdata", rsp_rdata[0], exp[31:0]);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 16'h0000;
        req_wdata[0] = 32'hBAD0BAD0;
      end
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      @(negedge clk);
      check($sformatf("bp hold%0d valid", i), 32'(rsp_valid[0]), 32'd1);
      check($sformatf("bp hold%0d rdata", i), rsp_rdata[0], exp[31:0]);
      check($sformatf("bp hold%0d req_ready", i), 32'(req_ready[0]), 32'd0);
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp release valid", 32'(rsp_valid[0]), 32'd0);
    check("bp release req_ready", 32'(req_ready[0]), 32'd1);
    check("bp release busy", 32'(busy[0]), 32'd0);
`ifdef SISC_MEM_STALL_CNT_EN
    check("bp stall_cnt", 32'(stall_cnt[0]), 32'd5);
`endif
    do_req(0, 1'b0, 16'h0000, 32'h0, 32'hCAFEF00D, 1'b0, "ignored write");

    // Reset while the write to 7 is still waiting: memory must keep the preloaded zero.
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 16'h0007;
    req_wdata[0] = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("midrst busy before", 32'(busy[0]), 32'd1);
    rst_f = 1'b0;
    #1;
    check("midrst busy", 32'(busy[0]), 32'd0);
    check("midrst req_ready", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    rst_f = 1'b1;
    do_req(0, 1'b0, 16'h0007, 32'h0, 32'h00000000, 1'b0, "midrst readback");

    // Zero wait-state instance.
    do_req(1, 1'b1, 16'h0003, 32'h33333333, 32'h00000000, 1'b0, "w0 write");
    do_req(1, 1'b0, 16'h0003, 32'h0, 32'h33333333, 1'b0, "w0 read");
    do_req(1, 1'b0, 16'h0200, 32'h0, 32'h00000000, 1'b1, "w0 oob");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
